// File: rtl/svc_rv_div.sv
// Iterative radix-2 restoring divider for RV32M/RV64M DIV, DIVU, REM and REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow finish immediately.
module svc_rv_div #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            flush,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            valid,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic            rem_sel_q, rem_sel_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            valid_q, valid_d;

    // Operand decode for the start cycle
    logic            is_signed;
    logic            rs1_neg;
    logic            rs2_neg;
    logic [XLEN-1:0] rs1_mag;
    logic [XLEN-1:0] rs2_mag;
    logic            div_zero;
    logic            sgn_ovf;
    logic            start;

    assign is_signed = ~op[0];
    assign rs1_neg   = is_signed & rs1[XLEN-1];
    assign rs2_neg   = is_signed & rs2[XLEN-1];
    assign rs1_mag   = rs1_neg ? (~rs1 + XLEN'(1)) : rs1;
    assign rs2_mag   = rs2_neg ? (~rs2 + XLEN'(1)) : rs2;
    assign div_zero  = (rs2 == '0);
    assign sgn_ovf   = is_signed & (rs1 == MIN_NEG) & (rs2 == '1);
    assign start     = (state_q == IDLE) & en & ~flush;

    // One restoring step: shift {rem, quo} left, trial-subtract the divisor
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   diff;
    logic            step_ok;
    logic [XLEN-1:0] rem_nx;
    logic [XLEN-1:0] quo_nx;
    logic [XLEN-1:0] quo_fin;
    logic [XLEN-1:0] rem_fin;

    assign rem_sh  = {rem_q, quo_q[XLEN-1]};
    // rem_sh < 2*divisor, so the top bit of the (XLEN+1)-bit difference is the borrow
    assign diff    = rem_sh - {1'b0, dvs_q};
    assign step_ok = ~diff[XLEN];
    assign rem_nx  = step_ok ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    assign quo_nx  = {quo_q[XLEN-2:0], step_ok};
    assign quo_fin = neg_quo_q ? (~quo_nx + XLEN'(1)) : quo_nx;
    assign rem_fin = neg_rem_q ? (~rem_nx + XLEN'(1)) : rem_nx;

    // Next-state and datapath control
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        rem_sel_d = rem_sel_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        valid_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    rem_sel_d = op[1];
                    neg_quo_d = rs1_neg ^ rs2_neg;
                    neg_rem_d = rs1_neg;
                    if (div_zero) begin
                        result_d = op[1] ? rs1 : '1;
                        valid_d  = 1'b1;
                        state_d  = DONE;
                    end else if (sgn_ovf) begin
                        result_d = op[1] ? '0 : rs1;
                        valid_d  = 1'b1;
                        state_d  = DONE;
                    end else begin
                        rem_d   = '0;
                        quo_d   = rs1_mag;
                        dvs_d   = rs2_mag;
                        cnt_d   = CW'(XLEN - 1);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    result_d = rem_sel_q ? rem_fin : quo_fin;
                    valid_d  = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Squash overrides everything: no result, back to IDLE
        if (flush) begin
            state_d  = IDLE;
            valid_d  = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            rem_sel_q <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            rem_sel_q <= rem_sel_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
        end
    end

    assign busy   = start | (state_q == CALC);
    assign valid  = valid_q;
    assign result = result_q;

endmodule
